decoder_leaf_n: RTL and testbench

DECODER_LEAF_N -- requirements
Module: decoder_leaf_n

---
 rtl/decoder_leaf_n.sv | 216 +++++++++++++++++++++
 tb/tb_decoder_leaf_n.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_leaf_n.sv
// Leaf packet decoder. Flits enter through a small FIFO. The first flit of each packet is a
// header that selects one of NOUT single-entry output registers. Packets whose destination is
// out of range are discarded and counted. One route-status token is emitted per packet.
module decoder_leaf_n #(
    parameter int unsigned W        = 9,
    parameter int unsigned NOUT     = 2,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ADDR_LSB = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [NOUT*W-1:0]     out_data,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [$clog2(NOUT):0] s_data,
    output logic [15:0]           drop_count
);

    localparam int unsigned AW = $clog2(NOUT);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRoute, StDrop} state_e;

    // Input FIFO
    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic            in_ready_q;

    // Output, status and decoder state
    logic [NOUT-1:0]   out_valid_q;
    logic [NOUT*W-1:0] out_data_q;
    logic              s_valid_q;
    logic [AW:0]       s_data_q;
    logic [15:0]       drop_count_q;
    state_e            state_q;
    logic [AW-1:0]     port_q;

    // Decode helpers
    logic [W-1:0]    head;
    logic            head_valid;
    logic            head_tail;
    logic [AW-1:0]   head_dest;
    logic            push, pop, fwd;
    logic            s_free, s_load, s_drop;
    logic [NOUT-1:0] out_free;
    logic [NOUT-1:0] load;
    logic [AW-1:0]   fwd_port;
    logic            dest_ok, dest_free, route_free;

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign head_tail  = head[W-1];
    assign head_dest  = head[ADDR_LSB +: AW];
    assign push       = in_valid && in_ready_q;
    assign s_free     = !s_valid_q || s_ready;
    assign out_free   = ~out_valid_q | out_ready;

    // Resolve the header destination and the free state of the relevant output registers
    always_comb begin
        dest_ok    = 1'b0;
        dest_free  = 1'b0;
        route_free = 1'b0;
        for (int p = 0; p < NOUT; p++) begin
            if (head_dest == AW'(p)) begin
                dest_ok   = 1'b1;
                dest_free = out_free[p];
            end
            if (port_q == AW'(p)) begin
                route_free = out_free[p];
            end
        end
    end

    // Decide whether the FIFO head is consumed this cycle and where it goes
    always_comb begin
        pop    = 1'b0;
        fwd    = 1'b0;
        s_load = 1'b0;
        s_drop = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A header always needs the status slot; routed headers also need their port
                if (head_valid && s_free) begin
                    if (!dest_ok) begin
                        pop    = 1'b1;
                        s_load = 1'b1;
                        s_drop = 1'b1;
                    end else if (dest_free) begin
                        pop    = 1'b1;
                        fwd    = 1'b1;
                        s_load = 1'b1;
                    end
                end
            end
            StRoute: begin
                if (head_valid && route_free) begin
                    pop = 1'b1;
                    fwd = 1'b1;
                end
            end
            StDrop: begin
                pop = head_valid;
            end
            default: ;
        endcase
        fwd_port = (state_q == StIdle) ? head_dest : port_q;
        for (int p = 0; p < NOUT; p++) begin
            load[p] = fwd && (fwd_port == AW'(p));
        end
    end

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers, occupancy and registered in_ready
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q    <= count_d;
            in_ready_q <= (count_d < (PW+1)'(DEPTH));
        end
    end

    // Per-port single-entry output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            for (int p = 0; p < NOUT; p++) begin
                if (load[p]) begin
                    out_valid_q[p]       <= 1'b1;
                    out_data_q[p*W +: W] <= head;
                end else if (out_ready[p]) begin
                    out_valid_q[p] <= 1'b0;
                end
            end
        end
    end

    // Decoder FSM with status token and saturating drop counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            port_q       <= '0;
            s_valid_q    <= 1'b0;
            s_data_q     <= '0;
            drop_count_q <= '0;
        end else begin
            if (s_load) begin
                s_valid_q <= 1'b1;
                s_data_q  <= {s_drop, head_dest};
            end else if (s_ready) begin
                s_valid_q <= 1'b0;
            end
            if (s_drop && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if (pop) begin
                unique case (state_q)
                    StIdle: begin
                        port_q <= head_dest;
                        // A header that is also a tail is a complete packet
                        if (!head_tail) begin
                            state_q <= dest_ok ? StRoute : StDrop;
                        end
                    end
                    StRoute, StDrop: begin
                        if (head_tail) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign s_valid    = s_valid_q;
    assign s_data     = s_data_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_decoder_leaf_n.sv
// Bench for decoder_leaf_n (NOUT=3 so that destination 3 is out of range).
// A packet-level model predicts per-port flit streams and status tokens; a compare
// process checks every output and status transfer against it. Directed tests
// add literal expectations.
module tb_decoder_leaf_n;

    localparam int W     = 9;
    localparam int NOUT  = 3;
    localparam int DEPTH = 2;

    logic              CLK;
    logic              RESET;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [NOUT-1:0]   out_valid;
    logic [NOUT-1:0]   out_ready;
    logic [NOUT*W-1:0] out_data;
    logic              s_valid;
    logic              s_ready;
    logic [2:0]        s_data;
    logic [15:0]       drop_count;

    decoder_leaf_n #(
        .W        (W),
        .NOUT     (NOUT),
        .DEPTH    (DEPTH),
        .ADDR_LSB (0)
    ) u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .drop_count (drop_count)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model state
    logic [W-1:0] exp_q [NOUT][$];
    logic [2:0]   sq[$];
    bit           in_pkt     = 0;
    bit           cur_drop   = 0;
    int           cur_dest   = 0;
    int           drops_seen = 0;
    int           n_in       = 0;

    // Delivery logs for literal checks
    logic [W-1:0] got_q [NOUT][$];
    int           got_t [NOUT][$];
    logic [2:0]   s_log[$];

    logic [W-1:0] pkt_q[$];
    logic [W-1:0] want_q[$];
    bit           send_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_true(input string name, input bit cond);
        n_total++;
        if (cond) n_pass++;
        else $display("FAIL %s: condition false, expected true", name);
    endtask

    initial begin
        CLK = 1'b0;
        forever begin
            #5 CLK = ~CLK;
            if (CLK) cyc++;
        end
    end

    // Compare process: checks transfers that will occur at the coming rising edge
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                for (int p = 0; p < NOUT; p++) exp_q[p].delete();
                sq.delete();
                in_pkt     = 0;
                drops_seen = 0;
            end else begin
                for (int p = 0; p < NOUT; p++) begin
                    if (out_valid[p] && out_ready[p]) begin
                        check_true($sformatf("port%0d_expected", p), exp_q[p].size() != 0);
                        if (exp_q[p].size() != 0)
                            check($sformatf("port%0d_data", p), out_data[p*W +: W],
                                  exp_q[p].pop_front());
                        got_q[p].push_back(out_data[p*W +: W]);
                        got_t[p].push_back(cyc);
                    end
                end
                if (s_valid && s_ready) begin
                    check_true("status_expected", sq.size() != 0);
                    if (sq.size() != 0) begin
                        logic [2:0] t;
                        t = sq.pop_front();
                        check("status_data", s_data, t);
                        if (t[2]) drops_seen++;
                        check("drop_count", drop_count, drops_seen);
                    end
                    s_log.push_back(s_data);
                end
                if (in_valid && in_ready) begin
                    n_in++;
                    if (!in_pkt) begin
                        cur_dest = int'(in_data[1:0]);
                        cur_drop = (cur_dest >= NOUT);
                        sq.push_back({cur_drop, in_data[1:0]});
                        in_pkt = !in_data[W-1];
                    end else if (in_data[W-1]) begin
                        in_pkt = 0;
                    end
                    if (!cur_drop) exp_q[cur_dest].push_back(in_data);
                end
            end
        end
    end

    task automatic clear_logs();
        for (int p = 0; p < NOUT; p++) begin
            got_q[p].delete();
            got_t[p].delete();
        end
        s_log.delete();
    endtask

    task automatic send_pkt();
        int  guard;
        bit  acc;
        send_done = 0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = pkt_q[i];
            guard    = 0;
            acc      = 0;
            while (!acc && guard < 200) begin
                @(negedge CLK);
                acc = in_ready;
                @(posedge CLK);
                #1;
                guard++;
            end
            check_true("send_accept", acc);
        end
        in_valid  = 1'b0;
        send_done = 1;
    endtask

    task automatic wait_send();
        int guard = 0;
        while (!send_done && guard < 300) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        check_true("send_done", send_done);
    endtask

    task automatic drain();
        int guard = 0;
        bit idle  = 0;
        while (!idle && guard < 300) begin
            @(posedge CLK);
            #1;
            guard++;
            idle = (out_valid == '0) && !s_valid && (sq.size() == 0) &&
                   (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0);
        end
        check_true("drain_done", idle);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic check_port(input string name, input int p);
        check({name, "_count"}, got_q[p].size(), want_q.size());
        for (int i = 0; i < want_q.size(); i++)
            if (i < got_q[p].size())
                check($sformatf("%s_flit%0d", name, i), got_q[p][i], want_q[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '1;
        s_ready   = 1'b1;
        send_done = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_s_data", s_data, 0);
        check("rst_drop_count", drop_count, 0);
        RESET = 1'b0;
        check("rst_in_ready_low", in_ready, 0);
        @(posedge CLK);
        #1;
        check("rst_in_ready_rise", in_ready, 1);

        // Three-flit packet to port 1 on consecutive cycles
        clear_logs();
        pkt_q = '{9'h001, 9'h055, 9'h1AA};
        send_pkt();
        drain();
        want_q = '{9'h001, 9'h055, 9'h1AA};
        check_port("t1_port1", 1);
        check("t1_port0_idle", got_q[0].size(), 0);
        if (got_t[1].size() == 3) begin
            check("t1_gap1", got_t[1][1] - got_t[1][0], 1);
            check("t1_gap2", got_t[1][2] - got_t[1][1], 1);
        end
        check("t1_status_n", s_log.size(), 1);
        if (s_log.size() > 0) check("t1_status", s_log[0], 3'b001);

        // Out-of-range destination is dropped and counted
        clear_logs();
        pkt_q = '{9'h003, 9'h0AB, 9'h1CD};
        send_pkt();
        drain();
        check("t2_no_out", got_q[0].size() + got_q[1].size() + got_q[2].size(), 0);
        check("t2_status_n", s_log.size(), 1);
        if (s_log.size() > 0) check("t2_status", s_log[0], 3'b111);
        check("t2_drops", drop_count, 1);
        clear_logs();
        pkt_q = '{9'h002, 9'h1EE};
        send_pkt();
        drain();
        want_q = '{9'h002, 9'h1EE};
        check_port("t2_port2", 2);
        if (s_log.size() > 0) check("t2_status2", s_log[0], 3'b010);

        // Single-flit packet, one-cycle latency, next flit is a header
        clear_logs();
        pkt_q = '{9'h100};
        send_pkt();
        check("t3_lat_before", out_valid, 3'b000);
        @(posedge CLK);
        #1;
        check("t3_lat_after", out_valid, 3'b001);
        pkt_q = '{9'h101};
        send_pkt();
        drain();
        want_q = '{9'h100};
        check_port("t3_port0", 0);
        want_q = '{9'h101};
        check_port("t3_port1", 1);
        check("t3_status_n", s_log.size(), 2);
        if (s_log.size() == 2) begin
            check("t3_status0", s_log[0], 3'b000);
            check("t3_status1", s_log[1], 3'b001);
        end

        // Stalled port 1: three flits held, then all six delivered in order
        begin
            int base;
            clear_logs();
            out_ready = 3'b101;
            pkt_q = '{9'h001, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FF};
            base = n_in;
            send_done = 0;
            fork
                send_pkt();
            join_none
            repeat (8) @(posedge CLK);
            #1;
            check("t4_in_ready", in_ready, 0);
            check("t4_held", n_in - base, 3);
            check("t4_out_valid", out_valid, 3'b010);
            check("t4_out_data", out_data[W +: W], 9'h001);
            out_ready = 3'b111;
            wait_send();
            drain();
            want_q = '{9'h001, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FF};
            check_port("t4_port1", 1);
        end

        // Stalled status: second header waits until the first token transfers
        clear_logs();
        s_ready = 1'b0;
        pkt_q = '{9'h100, 9'h101};
        send_done = 0;
        fork
            send_pkt();
        join_none
        repeat (8) @(posedge CLK);
        #1;
        check("t5_port0_n", got_q[0].size(), 1);
        if (got_q[0].size() > 0) check("t5_port0", got_q[0][0], 9'h100);
        check("t5_port1_stall", got_q[1].size(), 0);
        check("t5_out_valid", out_valid, 3'b000);
        check("t5_s_valid", s_valid, 1);
        check("t5_s_data", s_data, 3'b000);
        s_ready = 1'b1;
        wait_send();
        drain();
        want_q = '{9'h101};
        check_port("t5_port1", 1);
        check("t5_status_n", s_log.size(), 2);
        if (s_log.size() == 2) begin
            check("t5_status0", s_log[0], 3'b000);
            check("t5_status1", s_log[1], 3'b001);
        end

        // Reset mid-packet, then the next flit is a header
        clear_logs();
        pkt_q = '{9'h002, 9'h0A1};
        send_pkt();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("t6_out_valid", out_valid, 3'b000);
        check("t6_s_valid", s_valid, 0);
        check("t6_drops", drop_count, 0);
        check("t6_in_ready", in_ready, 0);
        RESET = 1'b0;
        clear_logs();
        pkt_q = '{9'h000, 9'h1BB};
        send_pkt();
        drain();
        want_q = '{9'h000, 9'h1BB};
        check_port("t6_port0", 0);
        check("t6_port2_idle", got_q[2].size(), 0);
        check("t6_status_n", s_log.size(), 1);
        if (s_log.size() > 0) check("t6_status", s_log[0], 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
